// File: rtl/channel_fir_mlane_if.sv
// Signal bundle for channel_fir_mlane: sample stream in/out plus the coefficient configuration port.
interface channel_fir_mlane_if #(
  parameter int LANES = 2,
  parameter int TAPS  = 8,
  parameter int DW    = 8,
  parameter int CW    = 10,
  parameter int OW    = 12
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                in_valid;
  logic [LANES*DW-1:0] in_data;
  logic                bypass;
  logic                cfg_we;
  logic [LW-1:0]       cfg_lane;
  logic [TW-1:0]       cfg_addr;
  logic [CW-1:0]       cfg_data;
  logic                cfg_commit;
  logic                cfg_busy;
  logic                out_valid;
  logic [LANES*OW-1:0] out_data;
  logic [LANES-1:0]    out_sat;

  modport master (
    output in_valid, in_data, bypass, cfg_we, cfg_lane, cfg_addr, cfg_data, cfg_commit,
    input  cfg_busy, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, bypass, cfg_we, cfg_lane, cfg_addr, cfg_data, cfg_commit,
    output cfg_busy, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/channel_fir_mlane.sv
// Multi-lane FIR channel emulator with double-buffered coefficients that swap only in an input gap.
// Two-stage pipeline: registered tap products, then sum/round/saturate.
module channel_fir_mlane #(
  parameter int LANES = 2,
  parameter int TAPS  = 8,
  parameter int DW    = 8,
  parameter int CW    = 10,
  parameter int FRAC  = 8,
  parameter int OW    = 12
) (
  input logic                clk,
  input logic                rstn,
  channel_fir_mlane_if.slave bus
);
  localparam int PW = DW + CW;
  localparam int AW = DW + CW + $clog2(TAPS);
  localparam int RW = AW + 1;  // one spare bit so adding the rounding constant cannot wrap

  typedef logic signed [DW-1:0] samp_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef enum logic {ST_IDLE, ST_PENDING} state_e;

  localparam coef_t                COEF_ONE = coef_t'(1 << FRAC);
  localparam logic signed [RW-1:0] HALF     = RW'(1 << (FRAC - 1));
  localparam logic signed [RW-1:0] OUT_MAX  = RW'((1 << (OW - 1)) - 1);
  localparam logic signed [RW-1:0] OUT_MIN  = ~OUT_MAX;

  state_e              state_q, state_d;
  logic                swap;
  logic                wr_ok;
  coef_t               shadow_q [LANES][TAPS];
  coef_t               active_q [LANES][TAPS];
  samp_t               hist_q   [LANES][TAPS];
  samp_t               hist_d   [LANES][TAPS];
  prod_t               prod_q   [LANES][TAPS];
  prod_t               prod_d   [LANES][TAPS];
  logic                valid1_q, bypass1_q;
  logic                out_valid_q;
  logic [LANES*OW-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]    out_sat_q, out_sat_d;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      ST_IDLE:    if (bus.cfg_commit) state_d = ST_PENDING;
      ST_PENDING: if (!bus.in_valid) begin
        swap    = 1'b1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  assign wr_ok = bus.cfg_we && (state_q == ST_IDLE) &&
                 (int'(bus.cfg_lane) < LANES) && (int'(bus.cfg_addr) < TAPS);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: <= everywhere in clocked blocks so every register samples pre-edge values.
      state_q <= ST_IDLE;
      // NOTE: both banks are reset element by element because identity is the required power-up response.
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < TAPS; k++) begin
          shadow_q[l][k] <= (k == 0) ? COEF_ONE : '0;
          active_q[l][k] <= (k == 0) ? COEF_ONE : '0;
        end
      end
    end else begin
      state_q <= state_d;
      if (wr_ok) shadow_q[bus.cfg_lane][bus.cfg_addr] <= coef_t'(bus.cfg_data);
      if (swap)  active_q <= shadow_q;
    end
  end

  // Products use the bank active in the sample's own cycle; a swap never coincides with in_valid.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      hist_d[l][0] = samp_t'(bus.in_data[l*DW +: DW]);
      for (int k = 1; k < TAPS; k++) hist_d[l][k] = hist_q[l][k-1];
      for (int k = 0; k < TAPS; k++) prod_d[l][k] = prod_t'(hist_d[l][k]) * prod_t'(active_q[l][k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid1_q  <= 1'b0;
      bypass1_q <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < TAPS; k++) begin
          hist_q[l][k] <= '0;
          prod_q[l][k] <= '0;
        end
      end
    end else begin
      valid1_q <= bus.in_valid;
      if (bus.in_valid) begin
        bypass1_q <= bus.bypass;
        hist_q    <= hist_d;
        prod_q    <= prod_d;
      end
    end
  end

  always_comb begin
    logic signed [AW-1:0] acc;
    logic signed [RW-1:0] rnd;
    acc        = '0;
    rnd        = '0;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    for (int l = 0; l < LANES; l++) begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) acc = acc + AW'(prod_q[l][k]);
      rnd = (RW'(acc) + HALF) >>> FRAC;
      if (valid1_q) begin
        out_sat_d[l] = 1'b0;
        if (bypass1_q) begin
          out_data_d[l*OW +: OW] = OW'(hist_q[l][0]);
        end else if (rnd > OUT_MAX) begin
          out_data_d[l*OW +: OW] = OUT_MAX[OW-1:0];
          out_sat_d[l]           = 1'b1;
        end else if (rnd < OUT_MIN) begin
          out_data_d[l*OW +: OW] = OUT_MIN[OW-1:0];
          out_sat_d[l]           = 1'b1;
        end else begin
          out_data_d[l*OW +: OW] = rnd[OW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      out_valid_q <= valid1_q;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.cfg_busy  = (state_q == ST_PENDING);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule
